// File: rtl/plat_pkg.sv
// Shared types and constants for the platform sprite pixel front end.
package plat_pkg;
  localparam int NUM_PLAT = 8;
  localparam int IDX_W    = 3;
  localparam int PLAT_W   = 64;
  localparam int PLAT_H   = 8;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam logic [23:0] KEY_RGB = 24'hFF00FF;

  localparam int XW     = $clog2(PLAT_W);
  localparam int YW     = $clog2(PLAT_H);
  localparam int ADDR_W = XW + YW;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } plat_entry_t;

  // Row*PLAT_W + col reduces to bit concatenation because PLAT_W is a power of 2.
  function automatic logic [ADDR_W-1:0] texel_addr(input logic [YW-1:0] row,
                                                   input logic [XW-1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/platform_pixel_pipe_if.sv
// Table-update, pixel-stream, sprite-ROM and colour-mapper signals of the pixel pipe.
interface platform_pixel_pipe_if
  import plat_pkg::*;
#(parameter int IDX_W = plat_pkg::IDX_W);
  logic             frame_start;
  logic             plat_we;
  logic [IDX_W-1:0] plat_idx;
  logic [9:0]       plat_x;
  logic [9:0]       plat_y;
  logic             plat_en;
  logic             pix_valid;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic [9:0]       rom_read_address;
  logic [23:0]      rom_data_Out;
  logic             plat_on;
  logic [23:0]      plat_rgb;
  logic [IDX_W-1:0] plat_hit_idx;

  modport master (
    output frame_start, plat_we, plat_idx, plat_x, plat_y, plat_en,
           pix_valid, DrawX, DrawY, rom_data_Out,
    input  rom_read_address, plat_on, plat_rgb, plat_hit_idx
  );

  modport slave (
    input  frame_start, plat_we, plat_idx, plat_x, plat_y, plat_en,
           pix_valid, DrawX, DrawY, rom_data_Out,
    output rom_read_address, plat_on, plat_rgb, plat_hit_idx
  );
endinterface

// File: rtl/plat_hit_test.sv
// Combinational hit test of one pixel against every slot; lowest slot index wins.
module plat_hit_test
  import plat_pkg::*;
#(
  parameter int NUM_PLAT = plat_pkg::NUM_PLAT,
  parameter int IDX_W    = plat_pkg::IDX_W
) (
  input  plat_entry_t [NUM_PLAT-1:0] tbl,
  input  logic [9:0]                 draw_x,
  input  logic [9:0]                 draw_y,
  output logic                       hit,
  output logic [IDX_W-1:0]           idx,
  output logic [ADDR_W-1:0]          addr
);
  logic [NUM_PLAT-1:0]             slot_hit;
  logic [NUM_PLAT-1:0][ADDR_W-1:0] slot_addr;

  for (genvar i = 0; i < NUM_PLAT; i++) begin : g_slot
    logic [10:0]   x_end, y_end;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    // 11-bit right/bottom edges so a platform near 1023 does not wrap to the left.
    assign x_end = {1'b0, tbl[i].x} + 11'(PLAT_W);
    assign y_end = {1'b0, tbl[i].y} + 11'(PLAT_H);
    assign slot_hit[i] = tbl[i].en
                       && (draw_x >= tbl[i].x) && ({1'b0, draw_x} < x_end)
                       && (draw_y >= tbl[i].y) && ({1'b0, draw_y} < y_end);
    // Low bits of the offset only depend on low bits of the operands.
    assign col = draw_x[XW-1:0] - tbl[i].x[XW-1:0];
    assign row = draw_y[YW-1:0] - tbl[i].y[YW-1:0];
    assign slot_addr[i] = texel_addr(row, col);
  end

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    addr = '0;
    for (int i = NUM_PLAT - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit  = 1'b1;
        idx  = IDX_W'(i);
        addr = slot_addr[i];
      end
    end
  end
endmodule

// File: rtl/platform_pixel_pipe.sv
// Double-buffered platform table, hit test, sprite ROM addressing and colour-key stage.
module platform_pixel_pipe
  import plat_pkg::*;
#(
  parameter int NUM_PLAT = plat_pkg::NUM_PLAT,
  parameter int IDX_W    = plat_pkg::IDX_W
) (
  input logic                  Clk,
  input logic                  Reset_n,
  platform_pixel_pipe_if.slave bus
);
  plat_entry_t [NUM_PLAT-1:0] shadow, active;

  logic              hit0;
  logic [IDX_W-1:0]  idx0;
  logic [ADDR_W-1:0] addr0;
  logic              take0;

  logic [2:1]                  vld_pipe;
  logic [2:1][IDX_W-1:0]       idx_pipe;
  logic                        opaque;

  // Commit copies the pre-write shadow; a same-cycle write lands for next frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (bus.frame_start) active <= shadow;
      if (bus.plat_we)     shadow[bus.plat_idx] <= {bus.plat_x, bus.plat_y, bus.plat_en};
    end
  end

  plat_hit_test #(.NUM_PLAT(NUM_PLAT), .IDX_W(IDX_W)) u_hit (
    .tbl    (active),
    .draw_x (bus.DrawX),
    .draw_y (bus.DrawY),
    .hit    (hit0),
    .idx    (idx0),
    .addr   (addr0)
  );

  assign take0  = bus.pix_valid && hit0;
  assign opaque = vld_pipe[2] && (bus.rom_data_Out != KEY_RGB);

  // Stage 1 issues the ROM address, stage 2 waits for the ROM, stage 3 keys.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_pipe         <= '0;
      idx_pipe         <= '0;
      bus.rom_read_address <= '0;
      bus.plat_on      <= 1'b0;
      bus.plat_rgb     <= '0;
      bus.plat_hit_idx <= '0;
    end else begin
      vld_pipe[1]          <= take0;
      idx_pipe[1]          <= take0 ? idx0 : '0;
      bus.rom_read_address <= take0 ? 10'(addr0) : '0;
      vld_pipe[2]          <= vld_pipe[1];
      idx_pipe[2]          <= idx_pipe[1];
      bus.plat_on          <= opaque;
      bus.plat_rgb         <= opaque ? bus.rom_data_Out : '0;
      bus.plat_hit_idx     <= idx_pipe[2];
    end
  end
endmodule

// File: tb/tb_platform_pixel_pipe.sv
// Directed bench for platform_pixel_pipe with a 1-cycle synchronous sprite ROM model.
module tb_platform_pixel_pipe;
  import plat_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [23:0] rom_mem [0:1023];

  platform_pixel_pipe_if #(.IDX_W(IDX_W)) bus ();

  platform_pixel_pipe #(.NUM_PLAT(NUM_PLAT), .IDX_W(IDX_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) bus.rom_data_Out <= rom_mem[bus.rom_read_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_slot(input int idx, input int x, input int y, input bit en,
                            input bit with_commit);
    @(negedge Clk);
    bus.plat_we     = 1'b1;
    bus.plat_idx    = IDX_W'(idx);
    bus.plat_x      = 10'(x);
    bus.plat_y      = 10'(y);
    bus.plat_en     = en;
    bus.frame_start = with_commit;
    @(negedge Clk);
    bus.plat_we     = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic commit();
    @(negedge Clk);
    bus.frame_start = 1'b1;
    @(negedge Clk);
    bus.frame_start = 1'b0;
  endtask

  // Present one pixel, check the address at t+1 and the keyed colour at t+3.
  task automatic run_pixel(input string tag, input int x, input int y, input bit valid,
                           input int exp_addr, input bit exp_on, input logic [23:0] exp_rgb,
                           input int exp_idx);
    @(negedge Clk);
    bus.DrawX     = 10'(x);
    bus.DrawY     = 10'(y);
    bus.pix_valid = valid;
    @(negedge Clk);
    bus.pix_valid = 1'b0;
    check({tag, ".addr"}, 32'(bus.rom_read_address), 32'(exp_addr));
    @(negedge Clk);
    @(negedge Clk);
    check({tag, ".on"},  32'(bus.plat_on),  32'(exp_on));
    check({tag, ".rgb"}, 32'(bus.plat_rgb), 32'(exp_rgb));
    if (exp_on) check({tag, ".idx"}, 32'(bus.plat_hit_idx), 32'(exp_idx));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 24'h100000 + 24'(i);
    rom_mem[131] = 24'h00C000;
    rom_mem[0]   = KEY_RGB;
    bus.frame_start = 1'b0;
    bus.plat_we     = 1'b0;
    bus.plat_idx    = '0;
    bus.plat_x      = '0;
    bus.plat_y      = '0;
    bus.plat_en     = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.rom_data_Out = '0;

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst.addr", 32'(bus.rom_read_address), 32'd0);
    check("rst.on",   32'(bus.plat_on),          32'd0);
    check("rst.rgb",  32'(bus.plat_rgb),         32'd0);
    check("rst.idx",  32'(bus.plat_hit_idx),     32'd0);
    Reset_n = 1'b1;

    // Reset mid-stream kills an in-flight pixel and clears the tables
    write_slot(0, 100, 200, 1'b1, 1'b0);
    commit();
    @(negedge Clk);
    bus.DrawX = 10'd103; bus.DrawY = 10'd202; bus.pix_valid = 1'b1;
    @(negedge Clk);
    bus.pix_valid = 1'b0;
    check("mid.addr_before", 32'(bus.rom_read_address), 32'd131);
    #2 Reset_n = 1'b0;
    #1;
    check("mid.addr_rst", 32'(bus.rom_read_address), 32'd0);
    check("mid.on_rst",   32'(bus.plat_on),          32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("mid.killed_on",  32'(bus.plat_on),  32'd0);
    check("mid.killed_rgb", 32'(bus.plat_rgb), 32'd0);
    run_pixel("mid.cleared", 103, 202, 1'b1, 0, 1'b0, 24'h0, 0);

    // Basic hit after rewrite and commit
    write_slot(0, 100, 200, 1'b1, 1'b0);
    commit();
    run_pixel("hit0",      103, 202, 1'b1, 131, 1'b1, 24'h00C000, 0);
    run_pixel("novalid",   103, 202, 1'b0, 0,   1'b0, 24'h0,      0);
    run_pixel("miss.right", 164, 200, 1'b1, 0,  1'b0, 24'h0,      0);
    run_pixel("miss.below", 100, 208, 1'b1, 0,  1'b0, 24'h0,      0);

    // Overlap priority: slot 2 beats slot 5
    write_slot(2, 0, 0, 1'b1, 1'b0);
    write_slot(5, 32, 4, 1'b1, 1'b0);
    commit();
    run_pixel("prio", 40, 5, 1'b1, 360, 1'b1, 24'h100168, 2);

    // Right edge near column 1023, no wrap
    write_slot(1, 1000, 470, 1'b1, 1'b0);
    commit();
    run_pixel("edge.hit",  1023, 477, 1'b1, 471, 1'b1, 24'h1001D7, 1);
    run_pixel("edge.miss", 5,    470, 1'b1, 0,   1'b0, 24'h0,      0);

    // Write coinciding with commit is deferred to the next frame
    write_slot(3, 50, 50, 1'b1, 1'b1);
    run_pixel("defer.miss", 51, 51, 1'b1, 0,  1'b0, 24'h0,      0);
    commit();
    run_pixel("defer.hit",  51, 51, 1'b1, 65, 1'b1, 24'h100041, 3);

    // Colour key on a hit
    run_pixel("key", 50, 50, 1'b1, 0, 1'b0, 24'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
